// File: rtl/alu_pkg.sv
// Shared ALU constants and types: default datapath width and the matching word type.
package alu_pkg;

    localparam int unsigned WIDTH = 32;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the ripple element of the subtractor chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/subtrator_32bits.sv
// Two's-complement subtractor S = A + ~B + 1 with carry-out and sign, plus registered copies.
module subtrator_32bits
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Signal,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q,
    output logic             Signal_q
);

    logic [WIDTH:0] carry;

    // Cin is reserved and deliberately kept out of the arithmetic.
    logic unused_cin;
    assign unused_cin = Cin;

    // Constant carry-in of 1 completes the two's-complement negation of B.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (A[i]),
            .b  (~B[i]),
            .ci (carry[i]),
            .s  (S[i]),
            .co (carry[i+1])
        );
    end

    assign Cout   = carry[WIDTH];
    assign Signal = S[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_q      <= '0;
            Cout_q   <= 1'b0;
            Signal_q <= 1'b0;
        end else begin
            S_q      <= S;
            Cout_q   <= Cout;
            Signal_q <= Signal;
        end
    end

endmodule

// File: tb/tb_subtrator_32bits.sv
// Directed-vector bench for subtrator_32bits: combinational results, Cin immunity, registers.
module tb_subtrator_32bits;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;
    logic        Signal;
    logic [31:0] S_q;
    logic        Cout_q;
    logic        Signal_q;

    int n_checks;
    int n_errors;

    subtrator_32bits u_dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S        (S),
        .Cout     (Cout),
        .Signal   (Signal),
        .S_q      (S_q),
        .Cout_q   (Cout_q),
        .Signal_q (Signal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one vector, wait 1 time unit, then check all three combinational outputs.
    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] exp_s, input logic exp_cout,
                       input logic exp_sig);
        A   = a;
        B   = b;
        Cin = ci;
        #1;
        check({tag, ".S"}, S, exp_s);
        check({tag, ".Cout"}, {31'd0, Cout}, {31'd0, exp_cout});
        check({tag, ".Signal"}, {31'd0, Signal}, {31'd0, exp_sig});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        A   = '0;
        B   = '0;
        Cin = 1'b0;
        #1;
        check("rst.S_q", S_q, 32'h0);
        check("rst.Cout_q", {31'd0, Cout_q}, 32'h0);
        check("rst.Signal_q", {31'd0, Signal_q}, 32'h0);

        // Combinational path runs while the registers are held in reset.
        vec("one_minus_zero", 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        vec("zero_minus_m1",  32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        vec("one_minus_m2",   32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        vec("m2_minus_m1",    32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        vec("one_minus_3",    32'h0000_0001, 32'h0000_0003, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        vec("eq_cin0",        32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        vec("eq_cin1",        32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        vec("overflow",       32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        vec("big_minus_sml",  32'h1234_5678, 32'h0000_1111, 1'b0, 32'h1234_4567, 1'b1, 1'b0);
        vec("cin_x",          32'h0000_0005, 32'h0000_0002, 1'bx, 32'h0000_0003, 1'b1, 1'b0);

        // Registers stay cleared across clock edges while rst is high.
        check("rst_held.S_q", S_q, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        A   = 32'h0000_0001;
        B   = 32'h0000_0003;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        check("reg1.S_q", S_q, 32'hFFFF_FFFE);
        check("reg1.Signal_q", {31'd0, Signal_q}, 32'h1);
        check("reg1.Cout_q", {31'd0, Cout_q}, 32'h0);

        @(negedge clk);
        A = 32'h0000_0005;
        B = 32'h0000_0002;
        #1;
        check("latency.S", S, 32'h0000_0003);
        check("latency.S_q", S_q, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        check("reg2.S_q", S_q, 32'h0000_0003);
        check("reg2.Cout_q", {31'd0, Cout_q}, 32'h1);
        check("reg2.Signal_q", {31'd0, Signal_q}, 32'h0);

        // Asynchronous clear between edges; combinational outputs unaffected.
        #2;
        rst = 1'b1;
        #1;
        check("async.S_q", S_q, 32'h0);
        check("async.Cout_q", {31'd0, Cout_q}, 32'h0);
        check("async.S", S, 32'h0000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
